discrete_range_controller: RTL and testbench
============================================

# discrete_range_controller

Sequencer that turns a request for a discrete variable into a randomly chosen assignment range for the MCMC solver. On a start pulse it reads the variable's assignment count from the discrete-sizes table and draws a uniform choice index from an internal 8-bit LFSR. It then fetches that entry's start/end from the discrete-values table and returns the range with a one-cycle done pulse. Both tables sit outside this block as combinational lookups; this block owns their address buses and all sequencing.

## Interface
- VALUE_WIDTH, 16: width of range start/end values (integer variable width).
- INDEX_WIDTH, 4: width of the discrete variable index.
- CHOICE_WIDTH, 4: width of the assignment index; a variable holds at most 2^CHOICE_WIDTH assignments.
- in_clock  in  1  sole clock; all state changes on the rising edge.
- in_reset  in  1  asynchronous, active-low reset.
- in_start  in  1  request pulse; accepted only in IDLE.
- in_variable_index  in  INDEX_WIDTH  variable to randomize; sampled when the start is accepted.
- in_load_seed  in  1  loads in_seed into the LFSR; honoured only in IDLE.
- in_seed  in  8  seed value; 8'h00 is replaced by 8'h01.
- out_size_index  out  INDEX_WIDTH  address to the sizes table.
- in_size  in  CHOICE_WIDTH+1  assignment count returned by the sizes table (combinational).
- out_table_variable  out  INDEX_WIDTH  variable address to the values table.
- out_table_entry  out  CHOICE_WIDTH  entry address to the values table.
- in_table_start, in_table_end  in  VALUE_WIDTH each  range returned by the values table (combinational).
- out_busy  out  1  high in every state except IDLE.
- out_done  out  1  one-cycle pulse when a result is ready.
- out_error  out  1  the last request found size 0; valid with out_done.
- out_choice  out  CHOICE_WIDTH  selected entry index.
- out_start, out_end  out  VALUE_WIDTH each  selected range.
- out_equal  out  1  out_start == out_end (combinational from the registered outputs).

## Operation
- States: IDLE, SIZE, DRAW, FETCH, DONE.
- IDLE:
  - in_start latches the variable index and moves to SIZE.
  - in_load_seed loads the LFSR. If in_load_seed and in_start arrive in the same cycle, the seed loads first and the draw uses the new seed.
- SIZE: out_size_index = the latched index; in_size is registered.
  - Size 0: out_error is set, out_choice/out_start/out_end are cleared, and the FSM goes directly to DONE.
  - Otherwise the FSM goes to DRAW.
- DRAW:
  - mask = smallest 2^k-1 that is >= S-1.
  - r = lfsr[CHOICE_WIDTH-1:0] & mask.
  - choice = r when r < S, otherwise r - S. Because mask < 2S, the result is always < S. S = 1 gives choice 0.
  - The LFSR advances exactly once.
  - The FSM moves to FETCH.
- FETCH: the table addresses are driven; in_table_start and in_table_end are registered into out_start and out_end.
- DONE: out_done = 1 for one cycle, then the FSM returns to IDLE.
- out_choice, out_start, out_end and out_error hold their values until the next result overwrites them.
- LFSR: 8-bit Galois, right shift.
  - If the LSB is 1: next = (lfsr >> 1) ^ 8'hB8.
  - If the LSB is 0: next = lfsr >> 1.
  - The LFSR changes only in DRAW or on a seed load.
- in_start and in_load_seed are ignored while out_busy is high.
- Table addresses hold their last value outside SIZE and FETCH.

## Timing
- Reset (in_reset = 0): the FSM goes to IDLE immediately and the LFSR becomes 8'h01. All outputs go to 0, including out_busy, out_done, out_error and both address buses.
- Reset mid-request aborts the request; no out_done is issued.
- Normal request, with in_start accepted at edge t:
  - SIZE at t+1, DRAW at t+2, FETCH at t+3.
  - out_done is high during cycle t+4; results are valid from t+4.
  - out_busy is high during t+1 to t+4.
- Size-0 request: out_done and out_error are high during cycle t+2; out_busy is high during t+1 to t+2.
- Back-to-back: a start asserted in the cycle after DONE (back in IDLE) is accepted, giving a throughput of one request per 5 cycles.
- Both tables must settle within one cycle; the block adds no wait states.

## Test plan
- Reset check: assert in_reset = 0 mid-FETCH -> all outputs 0 at once, and no done pulse follows. After release, load seed 0 -> LFSR reads 8'h01.
- Normal draw: load seed 8'h06; start var 3 with in_size = 5 (mask 7, r = 6) -> table entry addressed is (3, 1). With the table returning 10/20: out_done high at t+4, out_choice = 1, out_start = 10, out_end = 20, out_equal = 0, LFSR = 8'h03.
- Wrap and equal case: seed 8'h01, in_size = 1 -> out_choice = 0. Table returns 7/7 -> out_equal = 1. LFSR advances to 8'hB8.
- Zero size: in_size = 0 -> out_done at t+2, out_error = 1, out_start = out_end = 0, LFSR unchanged.
- Busy and concurrent inputs:
  - Pulse in_start and in_load_seed during DRAW -> both ignored; the result matches a run without them.
  - Start and load seed in the same IDLE cycle with seed 8'h06 -> the draw uses 8'h06.
- Uniformity: seed 8'h5A, in_size = 6, 1020 requests -> all choices lie in 0..5, and each value 0..5 appears at least once.

Source files
------------

// File: rtl/discrete_range_controller_if.sv
// rtl/discrete_range_controller_if.sv - request, table and result signals of the discrete range controller
interface discrete_range_controller_if #(
    parameter int VALUE_WIDTH  = 16,
    parameter int INDEX_WIDTH  = 4,
    parameter int CHOICE_WIDTH = 4
);
    logic                    in_start;
    logic [INDEX_WIDTH-1:0]  in_variable_index;
    logic                    in_load_seed;
    logic [7:0]              in_seed;
    logic [INDEX_WIDTH-1:0]  out_size_index;
    logic [CHOICE_WIDTH:0]   in_size;
    logic [INDEX_WIDTH-1:0]  out_table_variable;
    logic [CHOICE_WIDTH-1:0] out_table_entry;
    logic [VALUE_WIDTH-1:0]  in_table_start;
    logic [VALUE_WIDTH-1:0]  in_table_end;
    logic                    out_busy;
    logic                    out_done;
    logic                    out_error;
    logic [CHOICE_WIDTH-1:0] out_choice;
    logic [VALUE_WIDTH-1:0]  out_start;
    logic [VALUE_WIDTH-1:0]  out_end;
    logic                    out_equal;

    modport slave (
        input  in_start, in_variable_index, in_load_seed, in_seed,
        input  in_size, in_table_start, in_table_end,
        output out_size_index, out_table_variable, out_table_entry,
        output out_busy, out_done, out_error, out_choice, out_start, out_end, out_equal
    );

    modport master (
        output in_start, in_variable_index, in_load_seed, in_seed,
        output in_size, in_table_start, in_table_end,
        input  out_size_index, out_table_variable, out_table_entry,
        input  out_busy, out_done, out_error, out_choice, out_start, out_end, out_equal
    );
endinterface

// File: rtl/discrete_range_controller.sv
// rtl/discrete_range_controller.sv - picks a random assignment range for a discrete variable
module discrete_range_controller #(
    parameter int VALUE_WIDTH  = 16,
    parameter int INDEX_WIDTH  = 4,
    parameter int CHOICE_WIDTH = 4
) (
    input logic                        in_clock,
    input logic                        in_reset,
    discrete_range_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SIZE, DRAW, FETCH, DONE} state_t;

    state_t                  state;
    logic [7:0]              lfsr;
    logic [INDEX_WIDTH-1:0]  var_q;
    logic [CHOICE_WIDTH:0]   size_q;
    logic [CHOICE_WIDTH:0]   mask;
    logic [CHOICE_WIDTH:0]   r_val;
    logic [CHOICE_WIDTH-1:0] choice;
    logic [7:0]              lfsr_next;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);

    // Smearing S-1 downward gives the smallest all-ones mask covering it; mask < 2S keeps one subtraction enough.
    always_comb begin
        mask = size_q - 1'b1;
        for (int i = 1; i <= CHOICE_WIDTH; i++) begin
            mask = mask | (mask >> i);
        end
        r_val  = {1'b0, lfsr[CHOICE_WIDTH-1:0]} & mask;
        choice = CHOICE_WIDTH'((r_val < size_q) ? r_val : (r_val - size_q));
    end

    assign bus.out_equal = (bus.out_start == bus.out_end);

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state                  <= IDLE;
            lfsr                   <= 8'h01;
            var_q                  <= '0;
            size_q                 <= '0;
            bus.out_size_index     <= '0;
            bus.out_table_variable <= '0;
            bus.out_table_entry    <= '0;
            bus.out_busy           <= 1'b0;
            bus.out_done           <= 1'b0;
            bus.out_error          <= 1'b0;
            bus.out_choice         <= '0;
            bus.out_start          <= '0;
            bus.out_end            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_done <= 1'b0;
                    // The draw happens two states later, so a seed loaded alongside a start is what gets used.
                    if (bus.in_load_seed) begin
                        lfsr <= (bus.in_seed == 8'h00) ? 8'h01 : bus.in_seed;
                    end
                    if (bus.in_start) begin
                        var_q              <= bus.in_variable_index;
                        bus.out_size_index <= bus.in_variable_index;
                        bus.out_busy       <= 1'b1;
                        state              <= SIZE;
                    end
                end
                SIZE: begin
                    size_q <= bus.in_size;
                    if (bus.in_size == '0) begin
                        bus.out_error  <= 1'b1;
                        bus.out_choice <= '0;
                        bus.out_start  <= '0;
                        bus.out_end    <= '0;
                        bus.out_done   <= 1'b1;
                        state          <= DONE;
                    end else begin
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    lfsr                   <= lfsr_next;
                    bus.out_table_variable <= var_q;
                    bus.out_table_entry    <= choice;
                    state                  <= FETCH;
                end
                FETCH: begin
                    bus.out_start  <= bus.in_table_start;
                    bus.out_end    <= bus.in_table_end;
                    bus.out_choice <= bus.out_table_entry;
                    bus.out_error  <= 1'b0;
                    bus.out_done   <= 1'b1;
                    state          <= DONE;
                end
                DONE: begin
                    bus.out_done <= 1'b0;
                    bus.out_busy <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bus.out_done <= 1'b0;
                    bus.out_busy <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_discrete_range_controller.sv
// tb/tb_discrete_range_controller.sv - scoreboard bench for discrete_range_controller
module tb_discrete_range_controller;
    localparam int VW = 16;
    localparam int IW = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    discrete_range_controller_if #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .CHOICE_WIDTH(CW)) bus ();

    discrete_range_controller #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .CHOICE_WIDTH(CW)) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus)
    );

    logic [CW:0]   size_tab [16];
    logic [VW-1:0] tstart   [16][16];
    logic [VW-1:0] tend     [16][16];

    assign bus.in_size        = size_tab[bus.out_size_index];
    assign bus.in_table_start = tstart[bus.out_table_variable][bus.out_table_entry];
    assign bus.in_table_end   = tend[bus.out_table_variable][bus.out_table_entry];

    typedef struct {
        int            cyc;
        int            choice;
        logic [VW-1:0] s;
        logic [VW-1:0] e;
        logic          err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hist [16];
    logic [7:0] m_lfsr = 8'h01;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    function automatic int pick(input logic [7:0] v, input int size);
        int m;
        int r;
        m = 0;
        while (m < size - 1) m = m * 2 + 1;
        r = int'(v[CW-1:0]) & m;
        return (r < size) ? r : r - size;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && bus.out_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                x = sb.pop_front();
                check("done_cycle", cyc, x.cyc);
                check("choice", bus.out_choice, x.choice);
                check("start", bus.out_start, x.s);
                check("end", bus.out_end, x.e);
                check("error", bus.out_error, x.err);
                check("equal", bus.out_equal, (x.s == x.e));
                check("busy_at_done", bus.out_busy, 1);
                if (!x.err) hist[x.choice]++;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", bus.out_busy, 0);
        check("rst_done", bus.out_done, 0);
        check("rst_error", bus.out_error, 0);
        check("rst_choice", bus.out_choice, 0);
        check("rst_start", bus.out_start, 0);
        check("rst_end", bus.out_end, 0);
        check("rst_size_index", bus.out_size_index, 0);
        check("rst_table_variable", bus.out_table_variable, 0);
        check("rst_table_entry", bus.out_table_entry, 0);
    endtask

    task automatic load_seed(input logic [7:0] seed);
        @(negedge clk);
        bus.in_load_seed = 1'b1;
        bus.in_seed      = seed;
        m_lfsr           = (seed == 8'h00) ? 8'h01 : seed;
        @(posedge clk);
        #1;
        bus.in_load_seed = 1'b0;
    endtask

    // mode 0: plain, 1: poke start/seed during DRAW, 2: reset during FETCH
    task automatic request(input int v, input bit with_seed, input logic [7:0] seed, input int mode);
        exp_t x;
        int   size;
        bit   seen;
        @(negedge clk);
        check("idle_busy", bus.out_busy, 0);
        if (with_seed) begin
            bus.in_load_seed = 1'b1;
            bus.in_seed      = seed;
            m_lfsr           = (seed == 8'h00) ? 8'h01 : seed;
        end
        bus.in_start          = 1'b1;
        bus.in_variable_index = IW'(v);
        size = int'(size_tab[v]);
        if (size == 0) begin
            x.cyc = cyc + 2; x.choice = 0; x.s = '0; x.e = '0; x.err = 1'b1;
        end else begin
            x.cyc    = cyc + 4;
            x.choice = pick(m_lfsr, size);
            x.s      = tstart[v][x.choice];
            x.e      = tend[v][x.choice];
            x.err    = 1'b0;
            m_lfsr   = lfsr_step(m_lfsr);
        end
        if (mode != 2) sb.push_back(x);
        @(posedge clk);
        #1;
        bus.in_start     = 1'b0;
        bus.in_load_seed = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            @(negedge clk);
            if (mode == 1) begin
                bus.in_start          = (n == 2);
                bus.in_load_seed      = (n == 2);
                bus.in_seed           = 8'h33;
                bus.in_variable_index = IW'(7);
            end
            if (mode == 2 && n == 3) begin
                check("busy_in_fetch", bus.out_busy, 1);
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                repeat (3) begin
                    @(negedge clk);
                    check("no_done_in_reset", bus.out_done, 0);
                end
                rst_n  = 1'b1;
                m_lfsr = 8'h01;
                repeat (4) begin
                    @(negedge clk);
                    check("no_done_after_reset", bus.out_done, 0);
                end
                seen = 1'b1;
            end else if (bus.out_done) begin
                seen = 1'b1;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        bus.in_start          = 1'b0;
        bus.in_variable_index = '0;
        bus.in_load_seed      = 1'b0;
        bus.in_seed           = '0;
        for (int v = 0; v < 16; v++) begin
            size_tab[v] = 5'd9;
            hist[v] = 0;
            for (int e = 0; e < 16; e++) begin
                tstart[v][e] = VW'(v * 256 + e * 16);
                tend[v][e]   = VW'(v * 256 + e * 16 + e + 1);
            end
        end
        size_tab[0] = 5'd0;
        size_tab[2] = 5'd1;
        size_tab[3] = 5'd5;
        size_tab[4] = 5'd16;
        size_tab[5] = 5'd6;
        tstart[3][1] = 16'd10; tend[3][1] = 16'd20;
        tstart[2][0] = 16'd7;  tend[2][0] = 16'd7;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        load_seed(8'h06);
        request(3, 1'b0, 8'h00, 0);
        load_seed(8'h01);
        request(2, 1'b0, 8'h00, 0);
        request(0, 1'b0, 8'h00, 0);
        request(4, 1'b0, 8'h00, 0);
        request(3, 1'b0, 8'h00, 1);
        request(4, 1'b0, 8'h00, 0);
        request(3, 1'b1, 8'h06, 0);
        request(3, 1'b0, 8'h00, 2);
        load_seed(8'h00);
        request(4, 1'b0, 8'h00, 0);

        load_seed(8'h5A);
        for (int v = 0; v < 16; v++) hist[v] = 0;
        repeat (1020) request(5, 1'b0, 8'h00, 0);
        for (int v = 0; v < 6; v++) check($sformatf("uniform_hit_%0d", v), (hist[v] > 0), 1);
        for (int v = 6; v < 16; v++) check($sformatf("uniform_out_of_range_%0d", v), hist[v], 0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
